// File: rtl/multicycle_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller.
// The JUMP state exists only when MULTICYCLE_JUMP_EN is defined.
package multicycle_pkg;

    // Controller states; values are fixed so the debug state output is stable.
    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADR   = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXECUTE   = 4'd6,
        ALU_WB    = 4'd7,
`ifdef MULTICYCLE_JUMP_EN
        BRANCH    = 4'd8,
        JUMP      = 4'd9
`else
        BRANCH    = 4'd8
`endif
    } state_t;

    // Opcodes (instruction bits [31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes (instruction bits [5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU control encodings
    localparam logic [2:0] ALUC_AND = 3'b000;
    localparam logic [2:0] ALUC_OR  = 3'b001;
    localparam logic [2:0] ALUC_ADD = 3'b010;
    localparam logic [2:0] ALUC_SUB = 3'b110;
    localparam logic [2:0] ALUC_SLT = 3'b111;

    // ALU operand B select
    typedef enum logic [1:0] {
        SRCB_B      = 2'b00,
        SRCB_FOUR   = 2'b01,
        SRCB_IMM    = 2'b10,
        SRCB_IMM_SH = 2'b11
    } alu_src_b_t;

    // PC next-value select
    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10
    } pc_src_t;

    // ALU operation class handed to the ALU decoder; NONE yields 000.
    typedef enum logic [1:0] {
        ALUOP_NONE  = 2'b00,
        ALUOP_ADD   = 2'b01,
        ALUOP_SUB   = 2'b10,
        ALUOP_FUNCT = 2'b11
    } alu_op_t;

    // Per-state control word; the *_fetch/_branch/_on_ready bits are
    // qualified by live inputs in the top level.
    typedef struct packed {
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       pc_en_fetch;
        logic       pc_en_branch;
        logic       pc_en_jump;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        alu_src_b_t alu_src_b;
        alu_op_t    alu_op;
        pc_src_t    pc_src;
        logic       done;
        logic       done_on_ready;
    } ctrl_t;

    // Control word for a given state; anything not set stays 0.
    function automatic ctrl_t state_ctrl(state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.mem_read    = 1'b1;
                c.ir_write    = 1'b1;
                c.pc_en_fetch = 1'b1;
                c.alu_src_b   = SRCB_FOUR;
                c.alu_op      = ALUOP_ADD;
                c.pc_src      = PCSRC_ALU;
            end
            DECODE: begin
                c.alu_src_b = SRCB_IMM_SH;
                c.alu_op    = ALUOP_ADD;
            end
            MEM_ADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            MEM_READ: begin
                c.i_or_d   = 1'b1;
                c.mem_read = 1'b1;
            end
            MEM_WB: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
                c.done       = 1'b1;
            end
            MEM_WRITE: begin
                c.i_or_d        = 1'b1;
                c.mem_write     = 1'b1;
                c.done_on_ready = 1'b1;
            end
            EXECUTE: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_B;
                c.alu_op    = ALUOP_FUNCT;
            end
            ALU_WB: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
                c.done      = 1'b1;
            end
            BRANCH: begin
                c.alu_src_a    = 1'b1;
                c.alu_src_b    = SRCB_B;
                c.alu_op       = ALUOP_SUB;
                c.pc_src       = PCSRC_ALUOUT;
                c.pc_en_branch = 1'b1;
                c.done         = 1'b1;
            end
`ifdef MULTICYCLE_JUMP_EN
            JUMP: begin
                c.pc_src     = PCSRC_JUMP;
                c.pc_en_jump = 1'b1;
                c.done       = 1'b1;
            end
`endif
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// ALU decoder: maps the ALU operation class and funct field to alu_control,
// and flags funct codes the datapath does not support.
module multicycle_control_alu_decoder
    import multicycle_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_control,
    output logic       funct_valid
);

    // Funct is only consulted for the R-type class; other classes are always valid.
    always_comb begin
        alu_control = ALUC_AND;
        funct_valid = 1'b1;
        case (alu_op_t'(alu_op))
            ALUOP_ADD: alu_control = ALUC_ADD;
            ALUOP_SUB: alu_control = ALUC_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_control = ALUC_ADD;
                    FN_SUB:  alu_control = ALUC_SUB;
                    FN_AND:  alu_control = ALUC_AND;
                    FN_OR:   alu_control = ALUC_OR;
                    FN_SLT:  alu_control = ALUC_SLT;
                    default: funct_valid = 1'b0;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS-subset controller (add, sub, and, or, slt, lw, sw, beq).
// Define MULTICYCLE_JUMP_EN to add the JUMP state for opcode 000010.
// The per-state control word is registered alongside the state; only the
// bits that depend on mem_ready, zero or clear are qualified combinationally.
module multicycle_control
    import multicycle_pkg::*;
(
    input  logic       clock,
    input  logic       clear,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [1:0] pc_src,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state_dbg
);

    state_t state;
    state_t next_state;
    ctrl_t  ctrl;
    logic   decode_illegal;
    logic   exec_illegal;
    logic   funct_valid;
    logic   run;

    multicycle_control_alu_decoder alu_decoder (
        .alu_op      (ctrl.alu_op),
        .funct       (funct),
        .alu_control (alu_control),
        .funct_valid (funct_valid)
    );

    // Next-state selection and illegal-instruction detection.
    always_comb begin
        next_state     = state;
        decode_illegal = 1'b0;
        exec_illegal   = 1'b0;
        case (state)
            FETCH: if (mem_ready) next_state = DECODE;
            DECODE: begin
                case (opcode)
                    OP_RTYPE:     next_state = EXECUTE;
                    OP_LW, OP_SW: next_state = MEM_ADR;
                    OP_BEQ:       next_state = BRANCH;
`ifdef MULTICYCLE_JUMP_EN
                    OP_J:         next_state = JUMP;
`else
                    OP_J: begin
                        next_state     = FETCH;
                        decode_illegal = 1'b1;
                    end
`endif
                    default: begin
                        next_state     = FETCH;
                        decode_illegal = 1'b1;
                    end
                endcase
            end
            MEM_ADR:   next_state = (opcode == OP_SW) ? MEM_WRITE : MEM_READ;
            MEM_READ:  if (mem_ready) next_state = MEM_WB;
            MEM_WB:    next_state = FETCH;
            MEM_WRITE: if (mem_ready) next_state = FETCH;
            EXECUTE: begin
                if (funct_valid) begin
                    next_state = ALU_WB;
                end else begin
                    next_state   = FETCH;
                    exec_illegal = 1'b1;
                end
            end
            default:   next_state = FETCH;
        endcase
    end

    // State register with its registered control word; clear forces FETCH.
    always_ff @(posedge clock) begin
        if (clear) begin
            state <= FETCH;
            ctrl  <= state_ctrl(FETCH);
        end else begin
            state <= next_state;
            ctrl  <= state_ctrl(next_state);
        end
    end

    // While clear is high no write, read, retire or illegal may escape.
    assign run = ~clear;

    assign pc_en      = run & ((ctrl.pc_en_fetch & mem_ready) |
                               (ctrl.pc_en_branch & zero) |
                               ctrl.pc_en_jump);
    assign ir_write   = run & ctrl.ir_write & mem_ready;
    assign mem_read   = run & ctrl.mem_read;
    assign mem_write  = run & ctrl.mem_write;
    assign reg_write  = run & ctrl.reg_write;
    assign instr_done = run & (ctrl.done | (ctrl.done_on_ready & mem_ready));
    assign illegal    = run & (decode_illegal | exec_illegal);

    assign i_or_d     = ctrl.i_or_d;
    assign reg_dst    = ctrl.reg_dst;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign pc_src     = ctrl.pc_src;
    assign state_dbg  = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed testbench for multicycle_control. Every cycle the full output
// bundle plus the debug state is compared against a hand-computed vector.
module tb_multicycle_control;

    logic       clock = 1'b0;
    logic       clear = 1'b1;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_en, i_or_d, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_control;
    logic       instr_done, illegal;
    logic [3:0] state_dbg;

    int n_cmp = 0;
    int n_err = 0;

    // Scoreboard: per-cycle stimulus and expected observation
    logic [21:0] exp_q[$];
    logic        rdy_q[$];
    logic        zero_q[$];

    // {state, pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst,
    //  mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_control, pc_src,
    //  instr_done, illegal}
    logic [21:0] obs;
    assign obs = {state_dbg, pc_en, i_or_d, mem_read, mem_write, ir_write,
                  reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
                  alu_control, pc_src, instr_done, illegal};

    localparam logic [21:0] V_FETCH      = {4'd0, 9'b101010000, 2'b01, 3'b010, 2'b00, 2'b00};
    localparam logic [21:0] V_FETCH_WAIT = {4'd0, 9'b001000000, 2'b01, 3'b010, 2'b00, 2'b00};
    localparam logic [21:0] V_FETCH_CLR  = {4'd0, 9'b000000000, 2'b01, 3'b010, 2'b00, 2'b00};
    localparam logic [21:0] V_DECODE     = {4'd1, 9'b000000000, 2'b11, 3'b010, 2'b00, 2'b00};
    localparam logic [21:0] V_DECODE_ILL = {4'd1, 9'b000000000, 2'b11, 3'b010, 2'b00, 2'b01};
    localparam logic [21:0] V_MEM_ADR    = {4'd2, 9'b000000001, 2'b10, 3'b010, 2'b00, 2'b00};
    localparam logic [21:0] V_MEM_READ   = {4'd3, 9'b011000000, 2'b00, 3'b000, 2'b00, 2'b00};
    localparam logic [21:0] V_MEM_WB     = {4'd4, 9'b000000110, 2'b00, 3'b000, 2'b00, 2'b10};
    localparam logic [21:0] V_MEM_WB_CLR = {4'd4, 9'b000000100, 2'b00, 3'b000, 2'b00, 2'b00};
    localparam logic [21:0] V_MW_WAIT    = {4'd5, 9'b010100000, 2'b00, 3'b000, 2'b00, 2'b00};
    localparam logic [21:0] V_MW_DONE    = {4'd5, 9'b010100000, 2'b00, 3'b000, 2'b00, 2'b10};
    localparam logic [21:0] V_EXEC_ILL   = {4'd6, 9'b000000001, 2'b00, 3'b000, 2'b00, 2'b01};
    localparam logic [21:0] V_ALU_WB     = {4'd7, 9'b000001010, 2'b00, 3'b000, 2'b00, 2'b10};
    localparam logic [21:0] V_BR_TAKEN   = {4'd8, 9'b100000001, 2'b00, 3'b110, 2'b01, 2'b10};
    localparam logic [21:0] V_BR_NOT     = {4'd8, 9'b000000001, 2'b00, 3'b110, 2'b01, 2'b10};
    localparam logic [21:0] V_JUMP       = {4'd9, 9'b100000000, 2'b00, 3'b000, 2'b10, 2'b10};

    multicycle_control dut (
        .clock       (clock),
        .clear       (clear),
        .opcode      (opcode),
        .funct       (funct),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .pc_en       (pc_en),
        .i_or_d      (i_or_d),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .reg_write   (reg_write),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_control (alu_control),
        .pc_src      (pc_src),
        .instr_done  (instr_done),
        .illegal     (illegal),
        .state_dbg   (state_dbg)
    );

    // Clock and watchdog
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog timeout compared=%0d mismatched=%0d", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

    // Driver: queue one cycle of stimulus with its expected observation
    task automatic push(input logic r, input logic z, input logic [21:0] e);
        rdy_q.push_back(r);
        zero_q.push_back(z);
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        clear     = 1'b1;
        mem_ready = 1'b1;
        opcode    = 6'b000000;
        funct     = 6'b100000;
        @(posedge clock); #1;
        @(posedge clock); #1;
        @(negedge clock);
        n_cmp++;
        if (obs !== V_FETCH_CLR) begin
            n_err++;
            $display("FAIL reset_state obs=%h exp=%h", obs, V_FETCH_CLR);
        end
        @(posedge clock); #1;
        clear     = 1'b0;
        mem_ready = 1'b0;
    endtask

    task automatic test_rtype();
        logic [5:0] fn_tab[5]   = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        logic [2:0] aluc_tab[5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
        logic [21:0] e;
        int cyc;
        opcode = 6'b000000;
        for (int k = 0; k < 5; k++) begin
            funct = fn_tab[k];
            push(1'b1, 1'b0, V_FETCH);
            push(1'b1, 1'b0, V_DECODE);
            push(1'b1, 1'b0, {4'd6, 9'b000000001, 2'b00, aluc_tab[k], 2'b00, 2'b00});
            push(1'b1, 1'b0, V_ALU_WB);
            cyc = 0;
            while (exp_q.size() > 0) begin
                mem_ready = rdy_q.pop_front();
                zero      = zero_q.pop_front();
                e         = exp_q.pop_front();
                @(negedge clock);
                n_cmp++;
                if (obs !== e) begin
                    n_err++;
                    $display("FAIL rtype funct=%b cyc=%0d obs=%h exp=%h", funct, cyc, obs, e);
                end
                cyc++;
                @(posedge clock); #1;
            end
        end
    endtask

    task automatic test_lw_stall();
        logic [21:0] e;
        int cyc = 0;
        opcode = 6'b100011;
        push(1'b1, 1'b0, V_FETCH);
        push(1'b1, 1'b0, V_DECODE);
        push(1'b0, 1'b0, V_MEM_ADR);
        push(1'b0, 1'b0, V_MEM_READ);
        push(1'b0, 1'b0, V_MEM_READ);
        push(1'b1, 1'b0, V_MEM_READ);
        push(1'b0, 1'b0, V_MEM_WB);
        while (exp_q.size() > 0) begin
            mem_ready = rdy_q.pop_front();
            zero      = zero_q.pop_front();
            e         = exp_q.pop_front();
            @(negedge clock);
            n_cmp++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL lw_stall cyc=%0d obs=%h exp=%h", cyc, obs, e);
            end
            cyc++;
            @(posedge clock); #1;
        end
    endtask

    task automatic test_sw_stall();
        logic [21:0] e;
        int cyc = 0;
        opcode = 6'b101011;
        push(1'b1, 1'b0, V_FETCH);
        push(1'b1, 1'b0, V_DECODE);
        push(1'b1, 1'b0, V_MEM_ADR);
        push(1'b0, 1'b0, V_MW_WAIT);
        push(1'b1, 1'b0, V_MW_DONE);
        while (exp_q.size() > 0) begin
            mem_ready = rdy_q.pop_front();
            zero      = zero_q.pop_front();
            e         = exp_q.pop_front();
            @(negedge clock);
            n_cmp++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL sw_stall cyc=%0d obs=%h exp=%h", cyc, obs, e);
            end
            cyc++;
            @(posedge clock); #1;
        end
    endtask

    task automatic test_beq();
        logic [21:0] e;
        int cyc = 0;
        opcode = 6'b000100;
        // taken, with one fetch stall and mem_ready low where it is ignored
        push(1'b0, 1'b0, V_FETCH_WAIT);
        push(1'b1, 1'b0, V_FETCH);
        push(1'b0, 1'b0, V_DECODE);
        push(1'b0, 1'b1, V_BR_TAKEN);
        // not taken: still retires
        push(1'b1, 1'b0, V_FETCH);
        push(1'b1, 1'b0, V_DECODE);
        push(1'b1, 1'b0, V_BR_NOT);
        while (exp_q.size() > 0) begin
            mem_ready = rdy_q.pop_front();
            zero      = zero_q.pop_front();
            e         = exp_q.pop_front();
            @(negedge clock);
            n_cmp++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL beq cyc=%0d obs=%h exp=%h", cyc, obs, e);
            end
            cyc++;
            @(posedge clock); #1;
        end
        zero = 1'b0;
    endtask

    task automatic test_illegal();
        logic [21:0] e;
        int cyc = 0;
        opcode = 6'b000000;
        funct  = 6'b000111;
        push(1'b1, 1'b0, V_FETCH);
        push(1'b1, 1'b0, V_DECODE);
        push(1'b1, 1'b0, V_EXEC_ILL);
        push(1'b0, 1'b0, V_FETCH_WAIT);
        while (exp_q.size() > 0) begin
            mem_ready = rdy_q.pop_front();
            zero      = zero_q.pop_front();
            e         = exp_q.pop_front();
            @(negedge clock);
            n_cmp++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL illegal_funct cyc=%0d obs=%h exp=%h", cyc, obs, e);
            end
            cyc++;
            @(posedge clock); #1;
        end
        opcode = 6'b001000;
        funct  = 6'b100000;
        cyc    = 0;
        push(1'b1, 1'b0, V_FETCH);
        push(1'b1, 1'b0, V_DECODE_ILL);
        push(1'b0, 1'b0, V_FETCH_WAIT);
        while (exp_q.size() > 0) begin
            mem_ready = rdy_q.pop_front();
            zero      = zero_q.pop_front();
            e         = exp_q.pop_front();
            @(negedge clock);
            n_cmp++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL illegal_opcode cyc=%0d obs=%h exp=%h", cyc, obs, e);
            end
            cyc++;
            @(posedge clock); #1;
        end
    endtask

    task automatic test_jump_opcode();
        logic [21:0] e;
        int cyc = 0;
        opcode = 6'b000010;
        push(1'b1, 1'b0, V_FETCH);
`ifdef MULTICYCLE_JUMP_EN
        push(1'b1, 1'b0, V_DECODE);
        push(1'b0, 1'b0, V_JUMP);
`else
        push(1'b1, 1'b0, V_DECODE_ILL);
        push(1'b0, 1'b0, V_FETCH_WAIT);
`endif
        while (exp_q.size() > 0) begin
            mem_ready = rdy_q.pop_front();
            zero      = zero_q.pop_front();
            e         = exp_q.pop_front();
            @(negedge clock);
            n_cmp++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL jump_opcode cyc=%0d obs=%h exp=%h", cyc, obs, e);
            end
            cyc++;
            @(posedge clock); #1;
        end
    endtask

    task automatic test_clear_mid();
        logic [21:0] e;
        int cyc = 0;
        opcode = 6'b100011;
        push(1'b1, 1'b0, V_FETCH);
        push(1'b1, 1'b0, V_DECODE);
        push(1'b1, 1'b0, V_MEM_ADR);
        push(1'b1, 1'b0, V_MEM_READ);
        while (exp_q.size() > 0) begin
            mem_ready = rdy_q.pop_front();
            zero      = zero_q.pop_front();
            e         = exp_q.pop_front();
            @(negedge clock);
            n_cmp++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL clear_mid cyc=%0d obs=%h exp=%h", cyc, obs, e);
            end
            cyc++;
            @(posedge clock); #1;
        end
        // in MEM_WB: clear suppresses the write and the retire pulse
        clear = 1'b1;
        @(negedge clock);
        n_cmp++;
        if (obs !== V_MEM_WB_CLR) begin
            n_err++;
            $display("FAIL clear_in_mem_wb obs=%h exp=%h", obs, V_MEM_WB_CLR);
        end
        @(posedge clock); #1;
        clear     = 1'b0;
        mem_ready = 1'b0;
        @(negedge clock);
        n_cmp++;
        if (obs !== V_FETCH_WAIT) begin
            n_err++;
            $display("FAIL clear_to_fetch obs=%h exp=%h", obs, V_FETCH_WAIT);
        end
        @(posedge clock); #1;
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_stall();
        test_sw_stall();
        test_beq();
        test_illegal();
        test_jump_opcode();
        test_clear_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Finite-state controller that sequences the multi-cycle version of the team's MIPS-subset datapath (add, sub, and, or, slt, lw, sw, beq). It replaces the single-cycle combinational control unit and drives the register/memory write enables and mux selects of a shared instruction/data memory datapath, one micro-step per clock. A memory-ready input lets slow memory stall the sequence, and a one-cycle retire pulse marks each completed instruction.

## Interface
Parameters:
- none (all encodings live in the shared package)

Ports:
- clock  in  1  system clock, all state updates on rising edge
- clear  in  1  reset, synchronous, active-high
- opcode  in  6  instruction register bits [31:26]
- funct  in  6  instruction register bits [5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- pc_en  out  1  PC register load enable
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write strobe
- ir_write  out  1  instruction register load enable
- reg_dst  out  1  write register select: 0 = rt, 1 = rd
- mem_to_reg  out  1  write data select: 0 = ALUOut, 1 = MDR
- reg_write  out  1  register file write enable
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = register A
- alu_src_b  out  2  ALU B select: 00 = B, 01 = 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
- alu_control  out  3  and 000, or 001, add 010, sub 110, slt 111
- pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- instr_done  out  1  one-cycle retire pulse
- illegal  out  1  one-cycle pulse on unsupported opcode/funct

## Operation
- Moore FSM. States: FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB, MEM_WRITE, EXECUTE, ALU_WB, BRANCH, plus JUMP under the macro.
- FETCH: i_or_d=0, mem_read=1, alu_src_a=0, alu_src_b=01, add, pc_src=00. ir_write and pc_en assert only when mem_ready=1. Advances to DECODE on mem_ready; holds otherwise.
- DECODE: alu_src_a=0, alu_src_b=11, add (branch target into ALUOut). Next state by opcode:
  - 000000 → EXECUTE
  - 100011 / 101011 → MEM_ADR
  - 000100 → BRANCH
  - anything else → FETCH, with illegal=1
- MEM_ADR: alu_src_a=1, alu_src_b=10, add. lw → MEM_READ, sw → MEM_WRITE.
- MEM_READ: i_or_d=1, mem_read=1. Holds until mem_ready, then → MEM_WB.
- MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1, instr_done=1 → FETCH.
- MEM_WRITE: i_or_d=1. mem_write stays high until mem_ready. On mem_ready: instr_done=1 → FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00. alu_control is decoded from funct:
  - 100000 add
  - 100010 sub
  - 100100 and
  - 100101 or
  - 101010 slt
  - other funct: illegal=1 → FETCH, no write.
  - Legal funct → ALU_WB.
- ALU_WB: reg_dst=1, mem_to_reg=0, reg_write=1, instr_done=1 → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, sub, pc_src=01. pc_en=zero. instr_done=1 → FETCH.
- Every output not listed for a state is 0.

## Timing
- clear sampled on the rising edge: the next state is FETCH. While clear is high, every write enable, mem_read, instr_done and illegal is forced to 0.
- Reset mid-instruction abandons it; no partial register or memory write after the clear edge.
- Latency at mem_ready=1 throughout:
  - R-type: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - beq: 3 cycles
  - illegal: 2 cycles (DECODE) or 3 cycles (EXECUTE)
- Each cycle mem_ready is low in FETCH, MEM_READ or MEM_WRITE adds one cycle. Outputs are held constant during the stall.
- mem_ready is ignored in all other states.
- instr_done fires exactly once per retired instruction, in its last state.

## Configuration
- MULTICYCLE_JUMP_EN defined:
  - opcode 000010 goes DECODE → JUMP.
  - JUMP: pc_src=10, pc_en=1, instr_done=1 → FETCH. Latency 3 cycles.
- MULTICYCLE_JUMP_EN undefined: no JUMP state; 000010 is illegal.

## Structure
- Shared package multicycle_pkg holds:
  - state enum
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J
  - funct constants
  - alu_control encodings
  - alu_src_b and pc_src select encodings
- One sub-module: alu_decoder (combinational; ALU op class plus funct → alu_control, funct_valid), instantiated once.

## Test plan
- Clear pulse, then add with mem_ready=1 → states FETCH, DECODE, EXECUTE, ALU_WB; reg_write=1 and reg_dst=1 in cycle 4; instr_done pulse in cycle 4.
- lw, mem_ready low for 2 cycles in MEM_READ → 7 cycles total; mem_to_reg=1 and reg_write=1 only in MEM_WB.
- beq with zero=1 → pc_en=1, pc_src=01 in cycle 3. Same instruction with zero=0 → pc_en=0, instr_done still 1.
- sw with mem_ready low 1 cycle → mem_write high for 2 cycles with i_or_d=1; no reg_write; instr_done in cycle 5.
- R-type with funct 000111, then opcode 001000 → illegal pulse in EXECUTE and DECODE respectively; no write enables; return to FETCH.
- clear asserted during MEM_WB → no reg_write that cycle; FETCH next cycle. With MULTICYCLE_JUMP_EN defined, opcode 000010 → pc_src=10, pc_en=1 in cycle 3.
